// File: rtl/exu2_iter_div.sv
// EXU2 iterative radix-2 restoring divider for RV64 DIV/REM and their W forms.
// Stalls the EXU1->EXU2 register until the result is ready in DONE.
module exu2_iter_div #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_valid_i,
    input  logic            div_signed_i,
    input  logic            div_rem_i,
    input  logic            div_word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    input  logic            hold_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int HW = XLEN / 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  dvd_q, dvd_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic             rsel_q, rsel_d;
    logic             word_q, word_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    function automatic logic [XLEN-1:0] wfix(
        input logic [XLEN-1:0] v,
        input logic            w
    );
        return w ? {{HW{v[HW-1]}}, v[HW-1:0]} : v;
    endfunction

    // Operand conditioning at the operating width
    logic [XLEN-1:0] op1, op2, abs1, abs2, minneg, spec_res;
    logic            s1, s2, dz, ovf;

    always_comb begin
        if (div_word_i) begin
            op1 = {{HW{div_signed_i & src1_i[HW-1]}}, src1_i[HW-1:0]};
            op2 = {{HW{div_signed_i & src2_i[HW-1]}}, src2_i[HW-1:0]};
            minneg = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};
        end else begin
            op1 = src1_i;
            op2 = src2_i;
            minneg = {1'b1, {(XLEN-1){1'b0}}};
        end
        s1   = div_signed_i & op1[XLEN-1];
        s2   = div_signed_i & op2[XLEN-1];
        abs1 = s1 ? -op1 : op1;
        abs2 = s2 ? -op2 : op2;
        dz   = (op2 == '0);
        ovf  = div_signed_i & (op1 == minneg) & (op2 == '1);
        if (div_rem_i)
            spec_res = dz ? op1 : '0;
        else
            spec_res = dz ? '1 : op1;
        spec_res = wfix(spec_res, div_word_i);
    end

    // One restoring step; quotient bits shift into the dividend register
    logic [XLEN:0]   rem_sh, diff;
    logic            qbit;
    logic [XLEN-1:0] rem_nx, dvd_nx, q_fin, r_fin, fin;

    always_comb begin
        rem_sh = {rem_q, dvd_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        qbit   = ~diff[XLEN];
        rem_nx = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        dvd_nx = {dvd_q[XLEN-2:0], qbit};
        q_fin  = qneg_q ? -dvd_nx : dvd_nx;
        r_fin  = rneg_q ? -rem_nx : rem_nx;
        fin    = wfix(rsel_q ? r_fin : q_fin, word_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        rsel_d  = rsel_q;
        word_d  = word_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (div_valid_i) begin
                        rsel_d = div_rem_i;
                        word_d = div_word_i;
                        qneg_d = s1 ^ s2;
                        rneg_d = s1;
                        dvs_d  = abs2;
                        rem_d  = '0;
                        if (dz || ovf) begin
                            res_d   = spec_res;
                            state_d = S_DONE;
                        end else begin
                            dvd_d = div_word_i ?
                                {abs1[HW-1:0], {HW{1'b0}}} : abs1;
                            cnt_d = div_word_i ?
                                CNT_W'(HW) : CNT_W'(XLEN);
                            state_d = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    dvd_d = dvd_nx;
                    rem_d = rem_nx;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        res_d   = fin;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (!hold_i) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            rsel_q  <= 1'b0;
            word_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            rsel_q  <= rsel_d;
            word_q  <= word_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign stall_o  = ~flush_i &
                      (((state_q == S_IDLE) & div_valid_i) |
                       (state_q == S_BUSY));
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = res_q;

endmodule

// File: tb/tb_exu2_iter_div.sv
// Directed bench for exu2_iter_div: results, latency, flush, hold, reset.
module tb_exu2_iter_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_valid_i = 1'b0;
    logic        div_signed_i = 1'b0;
    logic        div_rem_i = 1'b0;
    logic        div_word_i = 1'b0;
    logic [63:0] src1_i = '0;
    logic [63:0] src2_i = '0;
    logic        flush_i = 1'b0;
    logic        hold_i = 1'b0;
    logic        stall_o, busy_o, done_o;
    logic [63:0] result_o;

    int total = 0;
    int bad = 0;

    exu2_iter_div dut (
        .clk         (clk),
        .rst         (rst),
        .div_valid_i (div_valid_i),
        .div_signed_i(div_signed_i),
        .div_rem_i   (div_rem_i),
        .div_word_i  (div_word_i),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .flush_i     (flush_i),
        .hold_i      (hold_i),
        .stall_o     (stall_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start(input string tag, input logic sg, input logic rm,
                         input logic wd, input logic [63:0] a,
                         input logic [63:0] b);
        @(negedge clk);
        div_valid_i  = 1'b1;
        div_signed_i = sg;
        div_rem_i    = rm;
        div_word_i   = wd;
        src1_i       = a;
        src2_i       = b;
        #1 chk({tag, " stall@T"}, 64'(stall_o), 64'd1);
    endtask

    // Called in accept cycle T; returns at the negedge of the first DONE cycle
    task automatic wait_done(input string tag, input logic [63:0] exp,
                             input int lat, input logic scramble);
        int k = 0;
        logic stall_ok = 1'b1;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (scramble) begin
                src1_i = ~src1_i;
                src2_i = src2_i + 64'd3;
            end
            if (done_o) break;
            if (!stall_o) stall_ok = 1'b0;
        end
        chk({tag, " latency"}, 64'(k), 64'(lat));
        chk({tag, " result"}, result_o, exp);
        chk({tag, " stall busy"}, 64'(stall_ok), 64'd1);
        chk({tag, " stall done"}, 64'(stall_o), 64'd0);
    endtask

    task automatic run_div(input string tag, input logic sg, input logic rm,
                           input logic wd, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp,
                           input int lat);
        start(tag, sg, rm, wd, a, b);
        wait_done(tag, exp, lat, 1'b0);
        div_valid_i = 1'b0;
        @(negedge clk);
        chk({tag, " idle"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst stall", 64'(stall_o), 64'd0);
        chk("rst busy", 64'(busy_o), 64'd0);
        chk("rst done", 64'(done_o), 64'd0);
        chk("rst result", result_o, 64'd0);

        run_div("divu", 0, 0, 0, 64'd100, 64'd7, 64'd14, 65);
        run_div("remu", 0, 1, 0, 64'd100, 64'd7, 64'd2, 65);
        run_div("rem", 1, 1, 0, -64'sd7, 64'd2, '1, 65);
        run_div("div", 1, 0, 0, -64'sd7, 64'd2,
                64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_div("divu0", 0, 0, 0, 64'h1234, 64'd0, '1, 1);
        run_div("remu0", 0, 1, 0, 64'h1234, 64'd0, 64'h1234, 1);
        run_div("divovf", 1, 0, 0, 64'h8000_0000_0000_0000, '1,
                64'h8000_0000_0000_0000, 1);
        run_div("removf", 1, 1, 0, 64'h8000_0000_0000_0000, '1,
                64'd0, 1);
        run_div("divuw", 0, 0, 1, 64'hFFFF_FFFF_8000_0000, 64'd1,
                64'hFFFF_FFFF_8000_0000, 33);
        run_div("divwovf", 1, 0, 1, 64'h0000_0000_8000_0000, '1,
                64'hFFFF_FFFF_8000_0000, 1);
        run_div("remw", 1, 1, 1, 64'h0000_0000_FFFF_FFF9, 64'd2,
                '1, 33);
        run_div("divw", 1, 0, 1, 64'd100, 64'h0000_0000_FFFF_FFF9,
                64'hFFFF_FFFF_FFFF_FFF2, 33);
        run_div("remuw", 0, 1, 1, 64'h1_0000_0064, 64'd7, 64'd2, 33);
        run_div("remw0", 1, 1, 1, 64'h5_8000_0001, 64'h7_0000_0000,
                64'hFFFF_FFFF_8000_0001, 1);

        // inputs changing after accept must not disturb the result
        start("scr", 0, 0, 0, 64'd1000, 64'd9);
        wait_done("scr", 64'd111, 65, 1'b1);
        div_valid_i = 1'b0;
        @(negedge clk);

        // flush mid-operation, then immediate re-accept
        begin
            logic saw_done = 1'b0;
            start("fl", 0, 0, 0, 64'd100, 64'd7);
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                if (done_o) saw_done = 1'b1;
            end
            flush_i = 1'b1;
            #1 chk("fl stall", 64'(stall_o), 64'd0);
            @(negedge clk);
            flush_i = 1'b0;
            src1_i  = 64'd200;
            chk("fl busy", 64'(busy_o), 64'd0);
            chk("fl nodone", 64'(saw_done | done_o), 64'd0);
            #1 chk("fl2 stall@T", 64'(stall_o), 64'd1);
            wait_done("fl2", 64'd28, 65, 1'b0);
            div_valid_i = 1'b0;
            @(negedge clk);
        end

        // downstream hold keeps DONE and the result steady
        hold_i = 1'b1;
        start("hold", 0, 0, 0, 64'd100, 64'd7);
        wait_done("hold", 64'd14, 65, 1'b0);
        div_valid_i = 1'b0;
        for (int i = 2; i <= 6; i++) begin
            @(negedge clk);
            chk("hold done", 64'(done_o), 64'd1);
            chk("hold res", result_o, 64'd14);
            chk("hold stall", 64'(stall_o), 64'd0);
            if (i == 6) hold_i = 1'b0;
        end
        @(negedge clk);
        chk("hold idle", 64'(busy_o), 64'd0);
        chk("hold done lo", 64'(done_o), 64'd0);

        // synchronous reset abandons an op in flight
        start("rstop", 0, 0, 0, 64'd100, 64'd7);
        repeat (5) @(negedge clk);
        div_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstop busy", 64'(busy_o), 64'd0);
        chk("rstop done", 64'(done_o), 64'd0);
        chk("rstop result", result_o, 64'd0);
        @(negedge clk);
        chk("rstop stays", 64'(busy_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exu2_iter_div.md
Name: exu2_iter_div

Overview:
- Iterative radix-2 restoring divider in the EXU2 stage of the RV64 pipeline; executes DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW.
- Sits downstream of the EXU1->EXU2 pipeline register and drives that register's stall (stallEX2) while a division is in flight.
- The register holds the instruction and its operands stable until the divider reports completion.
- Honors the pipeline flush and downstream hold.

Parameters:
- XLEN, 64, datapath width; word ops use the low XLEN/2 bits.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- div_valid_i  in  1  instruction currently in EXU2 is a divide/remainder
- div_signed_i  in  1  1 = signed (DIV/REM[W]), 0 = unsigned
- div_rem_i  in  1  1 = return remainder, 0 = return quotient
- div_word_i  in  1  1 = W variant (32-bit operands, sign-extended result)
- src1_i  in  XLEN  dividend (forwarded rs1 data)
- src2_i  in  XLEN  divisor (forwarded rs2 data)
- flush_i  in  1  kill the in-flight op (branch or forward flush of EXU2)
- hold_i  in  1  downstream stall; EXU2 may not retire this cycle
- stall_o  out  1  request hold of the EXU1->EXU2 register and upstream stages
- busy_o  out  1  FSM not IDLE
- done_o  out  1  result_o valid
- result_o  out  XLEN  quotient or remainder, final form

Behaviour:
- Reset: state=IDLE; stall_o=0, busy_o=0, done_o=0, result_o=0; counter and internal registers cleared. Reset mid-operation abandons the op immediately.
- FSM states: IDLE, BUSY, DONE.
- IDLE & div_valid_i & !flush_i (accept cycle T):
  - Latch operands and op bits; later changes of the inputs are ignored until the FSM returns to IDLE.
  - Word op: operands = low 32 bits, sign- or zero-extended per div_signed_i.
  - Signed: take absolute values; record quotient sign = s1^s2 and remainder sign = s1.
  - Divisor == 0 (word op: low 32 bits == 0): go to DONE. Quotient = all ones; remainder = original dividend (word: low 32 bits sign-extended).
  - Signed overflow (dividend = most-negative, divisor = -1, at the operating width): go to DONE. Quotient = dividend; remainder = 0.
  - Otherwise: go to BUSY with counter = N (N = 64, or 32 for word ops).
- BUSY:
  - One restoring step per cycle: shift partial remainder left by 1, bring in next dividend bit, trial-subtract the divisor, set quotient bit if the result is non-negative.
  - Counter decrements each cycle; when the counter reaches 0, go to DONE.
- DONE:
  - done_o=1.
  - result_o = selected quotient/remainder with signs restored; word ops sign-extend bit 31 to XLEN (also applies to DIVUW/REMUW).
  - result_o is registered and stable for the whole DONE residency.
  - Go to IDLE when !hold_i; remain in DONE while hold_i=1.
- stall_o (combinational) = !flush_i & ((IDLE & div_valid_i) | BUSY).
  - Deasserted in DONE, so the pipeline register advances exactly once.
- Latency, normal op accepted at T:
  - stall_o high for T .. T+N (N+1 cycles).
  - done_o high from T+N+1.
  - Special cases: done_o at T+1; stall_o high only at T.
- flush_i: any state -> IDLE next cycle. stall_o=0 in the flush cycle; done_o drops next cycle; no result produced. flush_i has priority over hold_i and over a new accept.
- Back-to-back divides:
  - The DONE -> IDLE cycle is the one in which the pipeline register loads the next instruction.
  - The next accept occurs in IDLE one cycle later; no op is ever accepted while in DONE.
- busy_o = (state != IDLE).

Test Plan:
- DIVU 100/7, accept at T -> stall_o high T..T+64; done_o at T+65, result 14. REMU same operands -> 2.
- REM src1=-7, src2=2 (signed, 64-bit) -> result 0xFFFF_FFFF_FFFF_FFFF (-1). DIV same operands -> -3 (0xFFFF_FFFF_FFFF_FFFD). Latency 65.
- DIVU x/0, x=0x1234 -> done at T+1, result all ones; REMU x/0 -> 0x1234. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM -> 0.
- DIVUW src1=0xFFFF_FFFF_8000_0000, src2=1 -> result 0xFFFF_FFFF_8000_0000 (sign-extended), done at T+33. DIVW 0x8000_0000 / -1 -> 0xFFFF_FFFF_8000_0000.
- flush_i pulsed at T+10 of a DIVU -> stall_o=0 that cycle, busy_o=0 at T+11, done_o never asserts. A new op accepted at T+11 completes with correct latency.
- hold_i=1 for 5 cycles after DONE entry -> done_o and result_o stable for 6 cycles; stall_o=0 throughout; IDLE reached one cycle after hold_i falls.
